pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen.sv | 204 ++++++++++++++++++++
 tb/tb_pwm_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// Three-phase center-aligned PWM with shadowed duty triple and dead-time insertion.
// Up/down carrier; new duties take effect at the carrier valley (cnt == 0).
module pwm_gen #(
    parameter int N  = 10,
    parameter int F  = 9,
    parameter int DT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         fault,
    input  logic [N-1:0] duty_a,
    input  logic [N-1:0] duty_b,
    input  logic [N-1:0] duty_c,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic [5:0]   gates,
    output logic         period_start
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } st_t;

    typedef enum logic [1:0] {
        PH_OFF,
        PH_LO,
        PH_HI,
        PH_DEAD
    } ph_t;

    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] CMP_MID = {1'b1, {(N-1){1'b0}}};
    localparam logic [7:0]   DT_LD   = 8'(DT - 1);

    st_t              r_state;
    st_t              w_state_nxt;
    logic [N-1:0]     r_cnt;
    logic             r_up;
    logic             r_full;
    logic [2:0][N-1:0] r_sh;
    logic [2:0][N-1:0] r_act;
    logic [2:0][N-1:0] w_cmp_in;
    logic             w_accept;
    logic             w_xfer;
    logic             w_run_keep;
    logic [2:0]       w_des;
    ph_t              r_ph [3];
    ph_t              w_ph_nxt [3];
    logic [2:0]       r_tgt;
    logic [2:0]       w_tgt_nxt;
    logic [7:0]       r_dt [3];
    logic [7:0]       w_dt_nxt [3];
    logic [5:0]       r_gates;
    logic [5:0]       w_gates_nxt;

    // Offset binary: the sign bit flips so -1 maps to 0 and 0 to mid-scale.
    assign w_cmp_in[0] = {~duty_a[F], duty_a[F-1:0]};
    assign w_cmp_in[1] = {~duty_b[F], duty_b[F-1:0]};
    assign w_cmp_in[2] = {~duty_c[F], duty_c[F-1:0]};

    // Top FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Top FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (enable && !fault) w_state_nxt = ST_RUN;
            ST_RUN:  if (!enable || fault) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Top FSM: outputs
    always_comb begin
        w_run_keep   = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
        period_start = (r_state == ST_RUN) && (r_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !w_run_keep) begin
            r_cnt <= '0;
            r_up  <= 1'b1;
        end else if (r_up) begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= CNT_MAX - 1'b1;
                r_up  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            if (r_cnt == '0) begin
                r_cnt <= {{(N-1){1'b0}}, 1'b1};
                r_up  <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign duty_ready = !r_full;
    assign w_accept   = duty_valid && !r_full;
    assign w_xfer     = r_full &&
                        (((r_state == ST_RUN) && (r_cnt == '0)) ||
                         ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)));

    // An accept coinciding with a transfer keeps the shadow full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_sh   <= {3{CMP_MID}};
            r_act  <= {3{CMP_MID}};
        end else begin
            if (w_xfer) r_act <= r_sh;
            if (w_accept) begin
                r_sh   <= w_cmp_in;
                r_full <= 1'b1;
            end else if (w_xfer) begin
                r_full <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_des[i] = r_act[i] > r_cnt;
        end
    end

    // Phase FSMs: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_ph[i] <= PH_OFF;
                r_dt[i] <= '0;
            end
            r_tgt   <= '0;
            r_gates <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_ph[i] <= w_ph_nxt[i];
                r_dt[i] <= w_dt_nxt[i];
            end
            r_tgt   <= w_tgt_nxt;
            r_gates <= w_gates_nxt;
        end
    end

    // Phase FSMs: next state
    always_comb begin
        w_tgt_nxt = r_tgt;
        for (int i = 0; i < 3; i++) begin
            w_ph_nxt[i] = r_ph[i];
            w_dt_nxt[i] = r_dt[i];
            if (!w_run_keep) begin
                w_ph_nxt[i]  = PH_OFF;
                w_tgt_nxt[i] = 1'b0;
                w_dt_nxt[i]  = '0;
            end else begin
                unique case (r_ph[i])
                    PH_DEAD: begin
                        if (w_des[i] != r_tgt[i]) begin
                            w_tgt_nxt[i] = w_des[i];
                            w_dt_nxt[i]  = DT_LD;
                        end else if (r_dt[i] == '0) begin
                            w_ph_nxt[i] = r_tgt[i] ? PH_HI : PH_LO;
                        end else begin
                            w_dt_nxt[i] = r_dt[i] - 1'b1;
                        end
                    end
                    PH_OFF, PH_LO, PH_HI: begin
                        if ((r_ph[i] == PH_OFF) ||
                            ((r_ph[i] == PH_HI) != w_des[i])) begin
                            w_ph_nxt[i]  = PH_DEAD;
                            w_tgt_nxt[i] = w_des[i];
                            w_dt_nxt[i]  = DT_LD;
                        end
                    end
                    default: w_ph_nxt[i] = PH_OFF;
                endcase
            end
        end
    end

    // Phase FSMs: gate decode, registered on the next edge
    always_comb begin
        w_gates_nxt = '0;
        for (int i = 0; i < 3; i++) begin
            w_gates_nxt[2*i]   = (w_ph_nxt[i] == PH_HI);
            w_gates_nxt[2*i+1] = (w_ph_nxt[i] == PH_LO);
        end
    end

    assign gates = r_gates;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with N=4, F=3, DT=2.
// Cycle Cn = n-th cycle after the edge that enters RUN.
module tb_pwm_gen;

    localparam int N  = 4;
    localparam int F  = 3;
    localparam int DT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         fault = 1'b0;
    logic [N-1:0] duty_a = '0;
    logic [N-1:0] duty_b = '0;
    logic [N-1:0] duty_c = '0;
    logic         duty_valid = 1'b0;
    logic         duty_ready;
    logic [5:0]   gates;
    logic         period_start;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_gen #(.N(N), .F(F), .DT(DT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fault        (fault),
        .duty_a       (duty_a),
        .duty_b       (duty_b),
        .duty_c       (duty_c),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .gates        (gates),
        .period_start (period_start)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        fault = 1'b0;
        duty_valid = 1'b0;
        duty_a = '0;
        duty_b = '0;
        duty_c = '0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, then free run at mid-scale compare (cmp=8)
        do_reset();
        chk("rst_gates", 8'(gates), 8'h00);
        chk("rst_ps", 8'(period_start), 8'h0);
        chk("rst_ready", 8'(duty_ready), 8'h1);
        enable = 1'b1;
        tick(); // C1
        chk("t1_c1_ps", 8'(period_start), 8'h1);
        chk("t1_c1_gates", 8'(gates), 8'h00);
        tick(); // C2
        chk("t1_c2_ps", 8'(period_start), 8'h0);
        chk("t1_c2_gates", 8'(gates), 8'h00);
        tick(); // C3
        chk("t1_c3_gates", 8'(gates), 8'h00);
        tick(); // C4
        chk("t1_c4_gates", 8'(gates), 8'h15);
        tick(5); // C9
        chk("t1_c9_gates", 8'(gates), 8'h15);
        tick(); // C10
        chk("t1_c10_gates", 8'(gates), 8'h00);
        tick(); // C11
        chk("t1_c11_gates", 8'(gates), 8'h00);
        tick(); // C12
        chk("t1_c12_gates", 8'(gates), 8'h2A);
        tick(12); // C24
        chk("t1_c24_gates", 8'(gates), 8'h2A);
        tick(); // C25
        chk("t1_c25_gates", 8'(gates), 8'h00);
        tick(); // C26
        chk("t1_c26_gates", 8'(gates), 8'h00);
        tick(); // C27
        chk("t1_c27_gates", 8'(gates), 8'h15);
        tick(3); // C30
        chk("t1_c30_ps", 8'(period_start), 8'h0);
        tick(); // C31
        chk("t1_c31_ps", 8'(period_start), 8'h1);
        tick(); // C32
        chk("t1_c32_ps", 8'(period_start), 8'h0);

        // duty_a = -1 (0x8): phase a held on the low side
        do_reset();
        duty_a = 4'h8;
        duty_b = 4'h0;
        duty_c = 4'h0;
        duty_valid = 1'b1;
        tick();
        chk("t2_ready_after_accept", 8'(duty_ready), 8'h0);
        duty_valid = 1'b0;
        enable = 1'b1;
        tick(); // C1
        chk("t2_c1_ready", 8'(duty_ready), 8'h1);
        chk("t2_c1_a", 8'(gates[1:0]), 8'h0);
        tick(2); // C3
        chk("t2_c3_a", 8'(gates[1:0]), 8'h0);
        for (int c = 4; c <= 40; c++) begin
            tick();
            chk($sformatf("t2_c%0d_a", c), 8'(gates[1:0]), 8'h2);
        end

        // Shadow handshake and valley-aligned transfer
        do_reset();
        enable = 1'b1;
        tick(); // C1
        tick(4); // C5
        duty_a = 4'h8;
        duty_b = 4'h0;
        duty_c = 4'h0;
        duty_valid = 1'b1;
        tick(); // C6
        chk("t3_c6_ready", 8'(duty_ready), 8'h0);
        duty_valid = 1'b0;
        tick(4); // C10
        duty_a = 4'h0;
        duty_valid = 1'b1;
        chk("t3_c10_ready", 8'(duty_ready), 8'h0);
        for (int c = 11; c <= 31; c++) begin
            tick();
            chk($sformatf("t3_c%0d_ready", c), 8'(duty_ready), 8'h0);
        end
        chk("t3_c31_ps", 8'(period_start), 8'h1);
        chk("t3_c31_a", 8'(gates[1:0]), 8'h1);
        tick(); // C32
        chk("t3_c32_a", 8'(gates[1:0]), 8'h1);
        tick(); // C33
        chk("t3_c33_a", 8'(gates[1:0]), 8'h0);
        chk("t3_c33_ready", 8'(duty_ready), 8'h0);
        duty_valid = 1'b0;
        tick(); // C34
        chk("t3_c34_a", 8'(gates[1:0]), 8'h0);
        tick(); // C35
        chk("t3_c35_a", 8'(gates[1:0]), 8'h2);
        tick(25); // C60
        chk("t3_c60_a", 8'(gates[1:0]), 8'h2);
        chk("t3_c60_ready", 8'(duty_ready), 8'h0);
        tick(); // C61
        chk("t3_c61_ps", 8'(period_start), 8'h1);
        chk("t3_c61_a", 8'(gates[1:0]), 8'h2);
        tick(); // C62
        chk("t3_c62_a", 8'(gates[1:0]), 8'h2);
        chk("t3_c62_ready", 8'(duty_ready), 8'h1);
        tick(); // C63
        chk("t3_c63_a", 8'(gates[1:0]), 8'h0);
        tick(2); // C65
        chk("t3_c65_a", 8'(gates[1:0]), 8'h1);

        // One-cycle fault while a_hi is on
        do_reset();
        enable = 1'b1;
        tick(4); // C4
        chk("t4_c4_gates", 8'(gates), 8'h15);
        fault = 1'b1;
        tick(); // C5
        chk("t4_c5_gates", 8'(gates), 8'h00);
        chk("t4_c5_ps", 8'(period_start), 8'h0);
        fault = 1'b0;
        enable = 1'b0;
        tick(); // C6
        chk("t4_c6_gates", 8'(gates), 8'h00);
        tick(); // C7
        chk("t4_c7_gates", 8'(gates), 8'h00);
        chk("t4_c7_ps", 8'(period_start), 8'h0);
        enable = 1'b1;
        tick(); // C8
        chk("t4_c8_ps", 8'(period_start), 8'h1);
        chk("t4_c8_gates", 8'(gates), 8'h00);
        tick(); // C9
        chk("t4_c9_gates", 8'(gates), 8'h00);
        tick(); // C10
        chk("t4_c10_gates", 8'(gates), 8'h00);
        tick(); // C11
        chk("t4_c11_gates", 8'(gates), 8'h15);

        // One-cycle reset in the middle of a dead time
        do_reset();
        enable = 1'b1;
        tick(); // C1
        duty_a = 4'h0;
        duty_b = 4'h0;
        duty_c = 4'h0;
        duty_valid = 1'b1;
        tick(); // C2
        chk("t5_c2_ready", 8'(duty_ready), 8'h0);
        chk("t5_c2_gates", 8'(gates), 8'h00);
        duty_valid = 1'b0;
        rst_n = 1'b0;
        tick(); // C3
        chk("t5_c3_gates", 8'(gates), 8'h00);
        chk("t5_c3_ps", 8'(period_start), 8'h0);
        chk("t5_c3_ready", 8'(duty_ready), 8'h1);
        rst_n = 1'b1;
        tick(); // C4
        chk("t5_c4_ps", 8'(period_start), 8'h1);
        chk("t5_c4_gates", 8'(gates), 8'h00);
        tick(); // C5
        chk("t5_c5_gates", 8'(gates), 8'h00);
        tick(); // C6
        chk("t5_c6_gates", 8'(gates), 8'h00);
        tick(); // C7
        chk("t5_c7_gates", 8'(gates), 8'h15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
